// File: rtl/reset_sequencer_pkg.sv
// Shared state type and sizing helpers for the board reset/clock bring-up sequencer.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } rstseq_state_t;

   localparam int RETRY_CNT_W = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Never return a zero-width counter, even for a limit of 1.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Button debouncer: 2-flop synchronizer followed by a stable-input counter that
// flips the output only after CYCLES consecutive disagreeing samples.
module debounce
   import reset_sequencer_pkg::*;
#(
   parameter int CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   localparam int CW = cnt_width(CYCLES);

   logic          in_p0;
   logic          in_s;
   logic [CW-1:0] stable_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_p0      <= 1'b0;
         in_s       <= 1'b0;
         stable_cnt <= '0;
         out        <= 1'b0;
      end else begin
         in_p0 <= in;
         in_s  <= in_p0;
         // Any agreeing sample restarts the run of disagreeing samples.
         if (in_s == out) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(CYCLES - 1)) begin
            out        <= ~out;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: debounces the reset button, pulses the MMCM reset and
// releases the SoC reset once lock has been held; retries on timeout or lock loss.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int PLL_RST_CYCLES  = 16,
   parameter int LOCK_TIMEOUT    = 100_000,
   parameter int HOLD_CYCLES     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   btn,
   input  logic                   pll_locked,
   output logic                   pll_rst,
   output logic                   core_rst_n,
   output logic                   running,
   output logic [RETRY_CNT_W-1:0] retry_cnt
);

   localparam int CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, HOLD_CYCLES));

   function automatic logic [RETRY_CNT_W-1:0] sat_inc(input logic [RETRY_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   rstseq_state_t    state;
   rstseq_state_t    state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             retry_inc;
   logic             btn_db;
   logic             lock_p0;
   logic             lock_s;

   debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk (clk),
      .rst (rst),
      .in  (btn),
      .out (btn_db)
   );

   // Stage boundary: lock synchronizer, state, shared counter, retry count
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_p0   <= 1'b0;
         lock_s    <= 1'b0;
         state     <= PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
      end else begin
         lock_p0 <= pll_locked;
         lock_s  <= lock_p0;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         if (retry_inc) begin
            retry_cnt <= sat_inc(retry_cnt);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      retry_inc = 1'b0;
      // A debounced press overrides every other transition and is not a retry.
      if (btn_db) begin
         state_nxt = PLL_RST;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            PLL_RST: begin
               if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = HOLD;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  state_nxt = PLL_RST;
                  cnt_nxt   = '0;
                  retry_inc = 1'b1;
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  state_nxt = PLL_RST;
                  cnt_nxt   = '0;
                  retry_inc = 1'b1;
               end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end
            end
            RUN: begin
               cnt_nxt = '0;
               if (!lock_s) begin
                  state_nxt = PLL_RST;
                  retry_inc = 1'b1;
               end
            end
            default: begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign pll_rst    = (state == PLL_RST);
   assign core_rst_n = (state == RUN);
   assign running    = core_rst_n;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed edge counts and retry values.
module tb_reset_sequencer;

   localparam int D  = 8;
   localparam int P  = 4;
   localparam int T  = 20;
   localparam int H  = 6;
   localparam int HN = 4096;

   localparam int PH_PLL  = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_HOLD = 2;
   localparam int PH_RUN  = 3;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       btn        = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       core_rst_n;
   logic       running;
   logic [3:0] retry_cnt;

   reset_sequencer #(
      .DEBOUNCE_CYCLES (D),
      .PLL_RST_CYCLES  (P),
      .LOCK_TIMEOUT    (T),
      .HOLD_CYCLES     (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .core_rst_n (core_rst_n),
      .running    (running),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: input history indexed by edge number, phase with entry timestamp.
   int edge_n       = 0;
   bit b_hist [HN];
   bit l_hist [HN];
   int m_phase      = PH_PLL;
   int m_entered    = 0;
   int m_retry      = 0;
   int m_last_clear = 0;
   bit m_db         = 1'b0;

   // Value seen by the logic at edge e after two synchronizer flops.
   function automatic bit sb(input int e);
      return (e >= 2) ? b_hist[e-2] : 1'b0;
   endfunction

   function automatic bit sl(input int e);
      return (e >= 2) ? l_hist[e-2] : 1'b0;
   endfunction

   always @(posedge clk) begin
      int n;
      int age;
      bit ls;
      bit flip;
      edge_n = edge_n + 1;
      n = edge_n;
      if (rst) begin
         b_hist[n]   = 1'b0;
         l_hist[n]   = 1'b0;
         b_hist[n-1] = 1'b0;
         l_hist[n-1] = 1'b0;
         m_phase      = PH_PLL;
         m_entered    = n;
         m_retry      = 0;
         m_db         = 1'b0;
         m_last_clear = n;
      end else begin
         b_hist[n] = btn;
         l_hist[n] = pll_locked;
         ls  = sl(n);
         age = n - m_entered;
         flip = (n - D + 1 > m_last_clear);
         for (int e = n - D + 1; e <= n; e++) begin
            if (sb(e) == m_db) flip = 1'b0;
         end
         if (m_db) begin
            m_phase   = PH_PLL;
            m_entered = n;
         end else begin
            case (m_phase)
               PH_PLL: begin
                  if (age == P) begin m_phase = PH_WAIT; m_entered = n; end
               end
               PH_WAIT: begin
                  if (ls) begin
                     m_phase = PH_HOLD; m_entered = n;
                  end else if (age == T) begin
                     m_phase = PH_PLL; m_entered = n;
                     m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                  end
               end
               PH_HOLD: begin
                  if (!ls) begin
                     m_phase = PH_PLL; m_entered = n;
                     m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                  end else if (age == H) begin
                     m_phase = PH_RUN; m_entered = n;
                  end
               end
               default: begin
                  if (!ls) begin
                     m_phase = PH_PLL; m_entered = n;
                     m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                  end
               end
            endcase
         end
         if (flip) begin
            m_db = !m_db;
            m_last_clear = n;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: actual 0x%0h, required 0x%0h", name, edge_n, act, exp);
      end
   endtask

   // One clock cycle, then compare all outputs against the model.
   task automatic tick();
      logic [6:0] exp;
      logic [6:0] act;
      @(posedge clk);
      #1;
      exp = {m_phase == PH_PLL, m_phase == PH_RUN, m_phase == PH_RUN, 4'(m_retry)};
      act = {pll_rst, core_rst_n, running, retry_cnt};
      check("model_outputs", 32'(act), 32'(exp));
   endtask

   task automatic wait_run(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (core_rst_n) break;
         tick();
      end
      check("wait_run", 32'(core_rst_n), 1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
      $fatal(1);
   end

   initial begin
      int   cnt_hi;
      int   k;
      int   j;
      int   r;
      int   rises;
      int   last_rise;
      logic all_hi;
      logic prev;

      repeat (3) tick();
      check("reset_pll_rst",    32'(pll_rst),    1);
      check("reset_core_rst_n", 32'(core_rst_n), 0);
      check("reset_running",    32'(running),    0);
      check("reset_retry_cnt",  32'(retry_cnt),  0);

      // Normal bring-up
      rst = 1'b0;
      cnt_hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (pll_rst) cnt_hi++;
         tick();
      end
      check("bringup_pll_rst_len", cnt_hi, 4);
      pll_locked = 1'b1;
      k = edge_n + 1;
      wait_run(40);
      check("bringup_lock_to_run", edge_n - k, 8);
      check("bringup_retry_cnt", 32'(retry_cnt), 0);

      // Lock loss in RUN
      repeat (3) tick();
      pll_locked = 1'b0;
      k = edge_n + 1;
      tick();
      tick();
      check("loss_still_run_k1", 32'(core_rst_n), 1);
      tick();
      check("loss_core_rst_n", 32'(core_rst_n), 0);
      check("loss_pll_rst",    32'(pll_rst),    1);
      check("loss_retry_cnt",  32'(retry_cnt),  1);
      pll_locked = 1'b1;
      wait_run(40);

      // Short button glitch while running
      all_hi = 1'b1;
      btn = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i == 5) btn = 1'b0;
         tick();
         all_hi = all_hi & core_rst_n;
      end
      check("glitch_core_rst_n", 32'(all_hi), 1);
      check("glitch_retry_cnt",  32'(retry_cnt), 1);

      // Held button press while running
      btn = 1'b1;
      j = edge_n + 1;
      for (int i = 0; i < 20 && !pll_rst; i++) tick();
      check("button_to_pll_rst", edge_n - j, 10);
      all_hi = 1'b1;
      while (edge_n < j + 29) begin
         tick();
         all_hi = all_hi & pll_rst;
      end
      btn = 1'b0;
      while (edge_n < j + 39) begin
         tick();
         all_hi = all_hi & pll_rst;
      end
      check("button_pll_rst_held", 32'(all_hi), 1);
      wait_run(60);
      check("button_retry_cnt", 32'(retry_cnt), 1);

      // Reset asserted during HOLD
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      for (int i = 0; i < 30 && m_phase != PH_HOLD; i++) tick();
      tick();
      tick();
      check("hold_before_rst", 32'({pll_rst, core_rst_n}), 0);
      rst = 1'b1;
      tick();
      check("midhold_pll_rst",    32'(pll_rst),    1);
      check("midhold_core_rst_n", 32'(core_rst_n), 0);
      check("midhold_running",    32'(running),    0);
      check("midhold_retry_cnt",  32'(retry_cnt),  0);
      check("midhold_cnt",        32'(dut.cnt),    0);
      repeat (2) tick();

      // Lock timeout and debounced press landing on the same edge
      pll_locked = 1'b0;
      rst = 1'b0;
      r = edge_n;
      while (edge_n < r + 13) tick();
      btn = 1'b1;
      while (edge_n < r + 23) tick();
      check("simul_wait_lock_pre", 32'(pll_rst), 0);
      tick();
      check("simul_pll_rst",   32'(pll_rst),   1);
      check("simul_retry_cnt", 32'(retry_cnt), 0);
      btn = 1'b0;

      // Repeated lock timeouts with saturation
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      rises = 0;
      last_rise = 0;
      for (int i = 0; i < 17 * 24; i++) begin
         prev = pll_rst;
         tick();
         if (pll_rst && !prev) begin
            rises++;
            if (rises > 1) check("timeout_period", edge_n - last_rise, 24);
            check("timeout_retry_cnt", 32'(retry_cnt), (rises > 15) ? 15 : rises);
            last_rise = edge_n;
         end
         if (!pll_rst && prev && rises > 0) check("timeout_pulse_len", edge_n - last_rise, 4);
      end
      check("timeout_rises", rises, 17);
      check("timeout_saturated", 32'(retry_cnt), 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
